// File: rtl/stage_sequencer.sv
// stage_sequencer: FETCH/DECODE/EXEC/UPDATE control FSM that computes the next PC for the PC register.
module stage_sequencer #(
    parameter int D  = 12,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic [D-1:0]  prog_ctr,
    input  logic          is_halt,
    input  logic          is_jump,
    input  logic          is_branch,
    input  logic          branch_cond,
    input  logic [OW-1:0] offset,
    input  logic [D-1:0]  jump_addr,
    output logic [1:0]    stage,
    output logic [D-1:0]  target,
    output logic          running,
    output logic          done,
    output logic [15:0]   instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED} state_t;
    state_t state, state_nx;
    logic halt_q;
    logic [D-1:0] off_ext;
    logic [D-1:0] target_nx;
    logic exec_done;
    assign off_ext   = D'($signed(offset));
    assign exec_done = state == EXEC && !stall;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = stall ? FETCH : DECODE;
            DECODE:  state_nx = stall ? DECODE : EXEC;
            EXEC:    state_nx = stall ? EXEC : UPDATE;
            UPDATE:  state_nx = halt_q ? HALTED : FETCH;
            HALTED:  state_nx = HALTED;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        target_nx = is_halt ? prog_ctr :
                    is_jump ? jump_addr :
                    (is_branch && branch_cond) ? prog_ctr + off_ext :
                    prog_ctr + D'(1);
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            halt_q      <= 1'b0;
            target      <= '0;
            stage       <= 2'b00;
            running     <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            state   <= state_nx;
            stage   <= state_nx == DECODE ? 2'b01 :
                       state_nx == EXEC   ? 2'b10 :
                       state_nx == UPDATE ? 2'b11 : 2'b00;
            running <= state_nx inside {FETCH, DECODE, EXEC, UPDATE};
            done    <= state_nx == HALTED;
            if (exec_done) begin
                target <= target_nx;
                halt_q <= is_halt;
            end
            if (state == UPDATE && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
        end
    end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM that drives the program counter's `stage` and `target` inputs. It steps every instruction through FETCH, DECODE, EXEC and UPDATE, and computes the next PC during EXEC. It sits between the decoder/ALU flags and the PC register, which loads `target` on the clock edge that ends stage 2'b11. It also holds execution while memory stalls and stops the machine on a halt instruction.

## Interface

- `D`, 12, program-counter width; must match the PC register.
- `OW`, 8, width of the signed relative branch offset; `OW` <= `D`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- `start`  in  1  in IDLE, begins execution at the current `prog_ctr`; ignored in all other states.
- `stall`  in  1  freezes the FSM in FETCH, DECODE or EXEC; ignored in UPDATE, IDLE and HALTED.
- `prog_ctr`  in  D  current PC value, fed back from the PC register.
- `is_halt`  in  1  decoded halt; sampled at the end of EXEC.
- `is_jump`  in  1  absolute jump; sampled at the end of EXEC.
- `is_branch`  in  1  conditional relative branch; sampled at the end of EXEC.
- `branch_cond`  in  1  branch condition flag; sampled at the end of EXEC.
- `offset`  in  OW  signed two's-complement branch offset.
- `jump_addr`  in  D  absolute jump destination.
- `stage`  out  2  stage code to the PC and datapath.
- `target`  out  D  next PC; valid while `stage`==2'b11.
- `running`  out  1  high in FETCH, DECODE, EXEC and UPDATE.
- `done`  out  1  high in HALTED.
- `instr_count`  out  16  number of completed UPDATE cycles; saturates.

## Operation

- States: IDLE, FETCH (`stage`=00), DECODE (01), EXEC (10), UPDATE (11), HALTED. In IDLE and HALTED, `stage`=00.
- The PC register loads `target` only when `stage`==11. Holding `stage` at 00 outside UPDATE therefore guarantees the PC never moves.
- Transitions:
  - IDLE -> FETCH when `start`=1.
  - FETCH -> DECODE -> EXEC when `stall`=0; each of these states holds while `stall`=1.
  - EXEC -> UPDATE when `stall`=0.
  - UPDATE -> FETCH unconditionally, or UPDATE -> HALTED if a halt was latched.
  - HALTED is terminal; only `reset` leaves it.
- Target computation happens on the EXEC -> UPDATE edge. Priority is halt > jump > branch > sequential:
  - halt: `target` = `prog_ctr`, and the halt flag is latched.
  - jump: `target` = `jump_addr`.
  - branch with `branch_cond`=1: `target` = `prog_ctr` + sign-extended `offset`, modulo 2^D.
  - otherwise: `target` = `prog_ctr` + 1, modulo 2^D.
- Arithmetic is D-bit with wrap-around and no overflow flag. Examples: 0xFFF + 1 = 0x000; 0x002 + (-4) = 0xFFE.
- `target` is a register. It changes only on the EXEC -> UPDATE edge and holds its value until the next such edge.
- `instr_count` increments on each UPDATE -> next-state edge, including the UPDATE of the halt instruction, and stops at 0xFFFF.
- `running`, `done` and `stage` are registered outputs decoded from the FSM state.

## Timing

- Reset values: state IDLE, `stage`=00, `target`=0, `running`=0, `done`=0, `instr_count`=0, halt flag 0.
- Reset mid-operation: all of the above clear asynchronously on the falling edge of `reset`, regardless of state. The FSM is back in IDLE after release.
- Latency from `start`:
  - `start` sampled high at edge k puts the FSM in FETCH after edge k.
  - UPDATE is reached after edge k+3 when there are no stalls.
  - The PC loads `target` at edge k+4.
- An unstalled instruction takes exactly 4 cycles. Each stalled cycle adds one cycle in the state where the stall occurs.
- `stall` asserted in the same cycle the FSM is in UPDATE has no effect; the FSM leaves UPDATE on the next edge.
- Inputs `is_*`, `branch_cond`, `offset` and `jump_addr` are don't-care except in the EXEC cycle where `stall`=0.
- Simultaneous `is_jump` and `is_branch`: the jump wins.
- Simultaneous `is_halt` with any other flag: the halt wins, and `target` = `prog_ctr`.
- HALTED is entered on the edge ending the halt instruction's UPDATE; `done`=1 from that cycle onward.

## Test plan

- Sequential run: `prog_ctr`=0x010, no flags, `start` pulse -> `stage` goes 00, 01, 10, 11; `target`=0x011 in UPDATE; `instr_count`=1 after UPDATE.
- Branch with wrap: `prog_ctr`=0x002, `is_branch`=1, `branch_cond`=1, `offset`=0xFC -> `target`=0xFFE. Repeat with `branch_cond`=0 -> `target`=0x003.
- Jump vs branch priority: `is_jump`=1, `is_branch`=1, `branch_cond`=1, `jump_addr`=0x3A5 -> `target`=0x3A5.
- Stall: `stall`=1 for 3 cycles during DECODE -> `stage` holds 01 for 4 cycles total; the instruction completes in 7 cycles; `target` is unaffected.
- Halt: `is_halt`=1 with `is_jump`=1, `prog_ctr`=0x020 -> `target`=0x020; then `done`=1, `running`=0, `stage`=00 permanently; later `start` pulses are ignored.
- Async reset in EXEC with `instr_count`=5 -> outputs clear immediately (`stage`=00, `instr_count`=0); FSM is in IDLE after release; a new `start` runs normally.
